sipo_buffer: RTL and testbench

- Serial-in parallel-out collector: gathers DEPTH words of WIDTH bits from a valid/ready word stream into one parallel block. It is the inverse of the team's PISO output buffer.
- Sits at the SHAKE input side. It assembles 64-bit lanes into a rate-sized block for the absorb stage.
- Supports early block termination via in_last. Unfilled slots read as zero, and the block reports its word count.

---
 rtl/shake_pkg.sv | 7 +
 rtl/sipo_buffer_if.sv | 20 ++
 rtl/sipo_buffer.sv | 79 +++++++
 tb/tb_sipo_buffer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// shake_pkg: shared SHAKE lane/rate constants and the block-buffer state type.
package shake_pkg;
    localparam int LANE_WIDTH     = 64;
    localparam int RATE_LANES_128 = 21;
    localparam int RATE_LANES_256 = 17;
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} buf_state_e;
endpackage

// File: rtl/sipo_buffer_if.sv
// sipo_buffer_if: serial word input and parallel block output of the SIPO buffer.
interface sipo_buffer_if import shake_pkg::*; #(
    parameter int WIDTH = LANE_WIDTH,
    parameter int DEPTH = RATE_LANES_256
);
    localparam int CW = $clog2(DEPTH + 1);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [DEPTH*WIDTH-1:0] out_data;
    logic [CW-1:0]          out_count;
    logic                   out_last;
    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_count, out_last);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_count, out_last);
endinterface

// File: rtl/sipo_buffer.sv
// sipo_buffer: collects up to DEPTH serial words into one parallel block, first word in the LSBs,
// with early close on in_last and zero-filled unused slots.
module sipo_buffer import shake_pkg::*; #(
    parameter int WIDTH = LANE_WIDTH,
    parameter int DEPTH = RATE_LANES_256
) (
    input logic          clk,
    input logic          rst,
    sipo_buffer_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    buf_state_e             state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [DEPTH*WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   last_q, last_d;
    logic                   in_ready, accept;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end
    assign in_ready = (state_q == FILL) ? 1'b1 : bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        if (state_q == FILL) begin
            if (accept) begin
                data_d[cnt_q*WIDTH +: WIDTH] = bus.in_data;
                if (cnt_q == CNTW'(DEPTH - 1) || bus.in_last) begin
                    state_d = FULL;
                    count_d = CW'(cnt_q) + CW'(1);
                    last_d  = bus.in_last;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
        end else if (bus.out_ready) begin
            // Handoff clears the whole block so an early-closed successor reads zero above its words.
            state_d = FILL;
            data_d  = '0;
            count_d = '0;
            last_d  = 1'b0;
            if (accept) begin
                data_d[WIDTH-1:0] = bus.in_data;
                if (DEPTH == 1 || bus.in_last) begin
                    state_d = FULL;
                    count_d = CW'(1);
                    last_d  = bus.in_last;
                end else begin
                    cnt_d = CNTW'(1);
                end
            end
        end
    end
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = (state_q == FULL);
        bus.out_data  = data_q;
        bus.out_count = count_q;
        bus.out_last  = last_q;
    end
endmodule

// File: tb/tb_sipo_buffer.sv
// tb_sipo_buffer: directed checks of a WIDTH=8 DEPTH=4 buffer and a DEPTH=1 build.
module tb_sipo_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] exp_blk [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    always #5 clk = ~clk;
    sipo_buffer_if #(.WIDTH(8), .DEPTH(4)) b ();
    sipo_buffer_if #(.WIDTH(8), .DEPTH(1)) b1 ();
    sipo_buffer #(.WIDTH(8), .DEPTH(4)) u_dut (.clk(clk), .rst(rst), .bus(b));
    sipo_buffer #(.WIDTH(8), .DEPTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic l);
        b.in_valid = 1'b1;
        b.in_data  = d;
        b.in_last  = l;
        @(posedge clk);
        #1;
        b.in_valid = 1'b0;
        b.in_last  = 1'b0;
    endtask
    task automatic idle();
        @(posedge clk);
        #1;
    endtask
    initial begin
        b.in_valid = 0; b.in_data = 0; b.in_last = 0; b.out_ready = 1;
        b1.in_valid = 0; b1.in_data = 0; b1.in_last = 0; b1.out_ready = 0;
        #12;
        chk("rst_valid", 32'(b.out_valid), 32'd0);
        chk("rst_data", b.out_data, 32'd0);
        chk("rst_count", 32'(b.out_count), 32'd0);
        chk("rst_last", 32'(b.out_last), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();
        chk("rst_ready", 32'(b.in_ready), 32'd1);
        // full block
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        chk("full_not_yet", 32'(b.out_valid), 32'd0);
        send(8'h44, 0);
        chk("full_valid", 32'(b.out_valid), 32'd1);
        chk("full_data", b.out_data, 32'h44332211);
        chk("full_count", 32'(b.out_count), 32'd4);
        chk("full_last", 32'(b.out_last), 32'd0);
        idle();
        chk("drain_valid", 32'(b.out_valid), 32'd0);
        chk("drain_data", b.out_data, 32'd0);
        // early termination
        send(8'hAA, 0); send(8'hBB, 1);
        chk("early_valid", 32'(b.out_valid), 32'd1);
        chk("early_data", b.out_data, 32'h0000BBAA);
        chk("early_count", 32'(b.out_count), 32'd2);
        chk("early_last", 32'(b.out_last), 32'd1);
        idle();
        send(8'hCC, 1);
        chk("early2_data", b.out_data, 32'h000000CC);
        chk("early2_count", 32'(b.out_count), 32'd1);
        idle();
        // backpressure
        b.out_ready = 0;
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        b.in_valid = 1; b.in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(b.in_ready), 32'd0);
            idle();
        end
        chk("bp_valid", 32'(b.out_valid), 32'd1);
        chk("bp_data", b.out_data, 32'h04030201);
        b.out_ready = 1;
        #1;
        chk("bp_pass_ready", 32'(b.in_ready), 32'd1);
        idle();
        b.in_valid = 0;
        chk("bp_handoff_valid", 32'(b.out_valid), 32'd0);
        chk("bp_handoff_data", b.out_data, 32'h00000055);
        send(8'h66, 0); send(8'h77, 0); send(8'h88, 0);
        chk("bp_next_data", b.out_data, 32'h88776655);
        chk("bp_next_count", 32'(b.out_count), 32'd4);
        idle();
        // continuous stream
        for (int i = 0; i < 12; i++) begin
            b.in_valid = 1; b.in_data = 8'(i + 1); b.in_last = 0;
            #1;
            chk("stream_ready", 32'(b.in_ready), 32'd1);
            @(posedge clk);
            #1;
            if (i % 4 == 3) begin
                chk("stream_valid", 32'(b.out_valid), 32'd1);
                chk("stream_data", b.out_data, exp_blk[i/4]);
            end
        end
        b.in_valid = 0;
        idle();
        chk("stream_drain", 32'(b.out_valid), 32'd0);
        // async reset mid-block
        send(8'h01, 0); send(8'h02, 0);
        chk("pre_rst_data", b.out_data, 32'h00000201);
        #3;
        rst = 1'b0;
        #1;
        chk("async_data", b.out_data, 32'd0);
        chk("async_count", 32'(b.out_count), 32'd0);
        chk("async_valid", 32'(b.out_valid), 32'd0);
        #2;
        rst = 1'b1;
        idle();
        send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'hF4, 0);
        chk("post_rst_data", b.out_data, 32'hF4F3F2F1);
        chk("post_rst_count", 32'(b.out_count), 32'd4);
        // DEPTH=1 build
        b1.in_valid = 1; b1.in_data = 8'hA5; b1.in_last = 0;
        idle();
        b1.in_valid = 0;
        chk("d1_valid", 32'(b1.out_valid), 32'd1);
        chk("d1_data", b1.out_data, 32'h000000A5);
        chk("d1_count", 32'(b1.out_count), 32'd1);
        b1.out_ready = 1; b1.in_valid = 1; b1.in_data = 8'h5A; b1.in_last = 1;
        idle();
        b1.in_valid = 0; b1.in_last = 0;
        chk("d1_hand_valid", 32'(b1.out_valid), 32'd1);
        chk("d1_hand_data", b1.out_data, 32'h0000005A);
        chk("d1_hand_count", 32'(b1.out_count), 32'd1);
        chk("d1_hand_last", 32'(b1.out_last), 32'd1);
        idle();
        chk("d1_drain_valid", 32'(b1.out_valid), 32'd0);
        chk("d1_drain_count", 32'(b1.out_count), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
